// File: rtl/board_commit_ctrl_pkg.sv
// Shared types and constants for the board commit controller.
// Board geometry, FSM states and the tile-position/nibble mapping.
package board_commit_ctrl_pkg;

    localparam int BOARD_W      = 64;
    localparam int TILE_W       = 4;
    localparam int N_TILES      = 16;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMMIT
    } state_t;

    // Tile position p (1 = top-left .. 16) lives in nibble 16-p.
    function automatic logic [3:0] pos_to_nibble(input logic [4:0] pos);
        pos_to_nibble = 4'(5'd16 - pos);
    endfunction

endpackage

// File: rtl/board_commit_ctrl_diff.sv
// Per-nibble inequality mask between two boards (combinational).
// Ports: i_a, i_b boards in; o_diff bit i set when nibble i differs.
module board_diff
    import board_commit_ctrl_pkg::*;
(
    input  logic [BOARD_W-1:0] i_a,
    input  logic [BOARD_W-1:0] i_b,
    output logic [N_TILES-1:0] o_diff
);

    always_comb begin
        o_diff = '0;
        for (int i = 0; i < N_TILES; i++) begin
            o_diff[i] = (i_a[i*TILE_W +: TILE_W] != i_b[i*TILE_W +: TILE_W]);
        end
    end

endmodule

// File: rtl/board_commit_ctrl.sv
// Buffers one board from game logic and commits it to the display copy
// only during vertical blanking, at most once per frame, with a held
// changed-tile mask for highlighting.
// Ports: clk, rst (async high); v_cnt line counter; upd_valid/new_board/
// upd_ready handshake; disp_board, changed_mask, hl_active, commit_pulse,
// frame_tick outputs.
module board_commit_ctrl
    import board_commit_ctrl_pkg::*;
#(
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int HOLD_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        v_cnt,
    input  logic               upd_valid,
    input  logic [BOARD_W-1:0] new_board,
    output logic               upd_ready,
    output logic [BOARD_W-1:0] disp_board,
    output logic [N_TILES-1:0] changed_mask,
    output logic               hl_active,
    output logic               commit_pulse,
    output logic               frame_tick
);

    localparam int            HW        = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [10:0]   V_ACT     = 11'(V_ACTIVE);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_vb_q;
    logic               r_vb_qq;
    logic               r_done;
    logic [BOARD_W-1:0] r_pending;
    logic [BOARD_W-1:0] r_disp;
    logic [N_TILES-1:0] r_mask;
    logic [HW-1:0]      r_hold;

    logic               w_vblank;
    logic               w_tick;
    logic               w_cond;
    logic               w_capture;
    logic               w_commit;
    logic [N_TILES-1:0] w_diff;

    assign w_vblank = (v_cnt >= V_ACT);
    assign w_tick   = r_vb_q & ~r_vb_qq;
    // The frame_tick term re-opens the commit window even while done is
    // still set from the previous frame's commit.
    assign w_cond   = r_vb_q & (~r_done | w_tick);

    board_diff u_diff (
        .i_a    (r_pending),
        .i_b    (r_disp),
        .o_diff (w_diff)
    );

    always_comb begin
        w_state_nxt  = r_state;
        upd_ready    = 1'b0;
        commit_pulse = 1'b0;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            IDLE: begin
                upd_ready = 1'b1;
                if (upd_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_cond) begin
                    w_commit    = 1'b1;
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit_pulse = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_vb_q  <= 1'b0;
            r_vb_qq <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vb_q  <= w_vblank;
            r_vb_qq <= r_vb_q;
            if (w_commit) begin
                r_done <= 1'b1;
            end else if (w_tick) begin
                r_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else if (w_capture) begin
            r_pending <= new_board;
        end
    end

    // A commit reloads the hold counter and replaces the mask outright;
    // otherwise the counter ages once per frame and wipes the mask at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp <= '0;
            r_mask <= '0;
            r_hold <= '0;
        end else if (w_commit) begin
            r_disp <= r_pending;
            r_mask <= w_diff;
            r_hold <= HOLD_INIT;
        end else if (w_tick && r_hold != '0) begin
            r_hold <= r_hold - HOLD_ONE;
            if (r_hold == HOLD_ONE) begin
                r_mask <= '0;
            end
        end
    end

    assign disp_board   = r_disp;
    assign changed_mask = r_mask;
    assign hl_active    = (r_hold != '0);
    assign frame_tick   = w_tick;

endmodule

// File: tb/tb_board_commit_ctrl.sv
// Self-checking bench for board_commit_ctrl.
// Frame-level reference model plus directed scenarios and random traffic.
module tb_board_commit_ctrl;

    localparam int HOLD = 3;
    localparam int VACT = 480;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] v_cnt = 11'd0;
    logic        upd_valid = 1'b0;
    logic [63:0] new_board = 64'd0;
    logic        upd_ready;
    logic [63:0] disp_board;
    logic [15:0] changed_mask;
    logic        hl_active;
    logic        commit_pulse;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    board_commit_ctrl #(
        .V_ACTIVE    (VACT),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .v_cnt        (v_cnt),
        .upd_valid    (upd_valid),
        .new_board    (new_board),
        .upd_ready    (upd_ready),
        .disp_board   (disp_board),
        .changed_mask (changed_mask),
        .hl_active    (hl_active),
        .commit_pulse (commit_pulse),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: frames are numbered by blanking onsets; a pending
    // board commits in the first blanking cycle of a frame that has not
    // yet seen a commit.
    bit          m_vb;
    bit          m_vbp;
    bit          m_pend;
    bit          m_pulse;
    logic [63:0] m_pboard;
    logic [63:0] m_disp;
    logic [15:0] m_mask;
    int          m_hold;
    int          m_frame;
    int          m_last;

    function automatic logic [15:0] nib_diff(input logic [63:0] a,
                                             input logic [63:0] b);
        logic [15:0] d;
        d = 16'd0;
        for (int i = 0; i < 16; i++) begin
            d[i] = (((a >> (4 * i)) & 64'hF) != ((b >> (4 * i)) & 64'hF));
        end
        return d;
    endfunction

    function automatic logic [83:0] mexp();
        return {(!m_pend && !m_pulse), m_disp, m_mask, (m_hold != 0),
                m_pulse, (m_vb && !m_vbp)};
    endfunction

    function automatic logic [83:0] dutv();
        return {upd_ready, disp_board, changed_mask, hl_active,
                commit_pulse, frame_tick};
    endfunction

    task automatic model_reset();
        m_vb     = 0;
        m_vbp    = 0;
        m_pend   = 0;
        m_pulse  = 0;
        m_pboard = 64'd0;
        m_disp   = 64'd0;
        m_mask   = 16'd0;
        m_hold   = 0;
        m_frame  = 0;
        m_last   = -1;
    endtask

    task automatic model_edge();
        bit ft;
        bit commit;
        bit capture;
        if (rst) begin
            model_reset();
            return;
        end
        ft      = m_vb && !m_vbp;
        commit  = m_pend && m_vb && (m_last != m_frame);
        capture = upd_valid && !m_pend && !m_pulse;
        if (commit) begin
            m_mask  = nib_diff(m_pboard, m_disp);
            m_disp  = m_pboard;
            m_hold  = HOLD;
            m_last  = m_frame;
            m_pend  = 0;
            m_pulse = 1;
        end else begin
            m_pulse = 0;
            if (ft && m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) m_mask = 16'd0;
            end
        end
        if (capture) begin
            m_pend   = 1;
            m_pboard = new_board;
        end
        m_vbp = m_vb;
        m_vb  = (v_cnt >= VACT);
        if (m_vb && !m_vbp) m_frame++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        v_cnt = (v_cnt == 11'd524) ? 11'd0 : v_cnt + 11'd1;
    endtask

    task automatic run_to(input logic [10:0] x);
        for (int n = 0; n < 1100 && v_cnt != x; n++) tick();
    endtask

    task automatic test_reset();
        logic [10:0] pv;
        int nticks;
        nticks = 0;
        checks++;
        if (dutv() !== {1'b1, 83'd0}) begin
            errors++;
            $display("FAIL reset_init: got %h expected %h", dutv(), {1'b1, 83'd0});
        end
        run_to(11'd300);
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dutv() !== {1'b1, 83'd0}) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", dutv(), {1'b1, 83'd0});
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            pv = v_cnt;
            tick();
            if (frame_tick) nticks++;
            checks++;
            if (disp_board !== 64'd0 || frame_tick !== (pv == 11'd480)) begin
                errors++;
                $display("FAIL idle_frame: got disp=%h tick=%b expected disp=0 tick=%b",
                         disp_board, frame_tick, (pv == 11'd480));
            end
        end
        checks++;
        if (nticks !== 1) begin
            errors++;
            $display("FAIL idle_tick_count: got %0d expected 1", nticks);
        end
    endtask

    task automatic test_active_update();
        run_to(11'd100);
        upd_valid = 1'b1;
        new_board = 64'h1000_0000_0000_0002;
        tick();
        upd_valid = 1'b0;
        new_board = {$urandom, $urandom};
        checks++;
        if (upd_ready !== 1'b0) begin
            errors++;
            $display("FAIL active_ready: got %b expected 0", upd_ready);
        end
        for (int n = 0; n < 600 && v_cnt != 11'd480; n++) begin
            tick();
            checks++;
            if (disp_board !== 64'd0 || commit_pulse !== 1'b0 || dutv() !== mexp()) begin
                errors++;
                $display("FAIL active_hold: got %h expected %h", dutv(), mexp());
            end
        end
        tick();
        checks++;
        if (disp_board !== 64'd0 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL active_t1: got disp=%h tick=%b expected disp=0 tick=1",
                     disp_board, frame_tick);
        end
        tick();
        checks++;
        if (disp_board !== 64'h1000_0000_0000_0002 || commit_pulse !== 1'b1 ||
            changed_mask !== 16'h8001 || hl_active !== 1'b1) begin
            errors++;
            $display("FAIL active_commit: got disp=%h pulse=%b mask=%h hl=%b expected 1000000000000002 1 8001 1",
                     disp_board, commit_pulse, changed_mask, hl_active);
        end
        tick();
        checks++;
        if (commit_pulse !== 1'b0 || upd_ready !== 1'b1) begin
            errors++;
            $display("FAIL active_after: got pulse=%b ready=%b expected 0 1",
                     commit_pulse, upd_ready);
        end
    endtask

    task automatic test_vblank_update();
        logic [63:0] b;
        logic [63:0] old;
        old = m_disp;
        b = {$urandom, $urandom};
        b[3:0] = ~old[3:0];
        run_to(11'd0);
        run_to(11'd500);
        upd_valid = 1'b1;
        new_board = b;
        tick();
        upd_valid = 1'b0;
        checks++;
        if (upd_ready !== 1'b0 || commit_pulse !== 1'b0) begin
            errors++;
            $display("FAIL vb_t1: got ready=%b pulse=%b expected 0 0", upd_ready, commit_pulse);
        end
        tick();
        checks++;
        if (disp_board !== b || commit_pulse !== 1'b1 || changed_mask !== nib_diff(b, old)) begin
            errors++;
            $display("FAIL vb_commit: got disp=%h pulse=%b mask=%h expected %h 1 %h",
                     disp_board, commit_pulse, changed_mask, b, nib_diff(b, old));
        end
        tick();
        checks++;
        if (upd_ready !== 1'b1 || commit_pulse !== 1'b0) begin
            errors++;
            $display("FAIL vb_t3: got ready=%b pulse=%b expected 1 0", upd_ready, commit_pulse);
        end
    endtask

    task automatic test_second_same_frame();
        logic [63:0] b1;
        logic [63:0] b2;
        b1 = m_disp;
        b2 = {$urandom, $urandom};
        b2[63:60] = ~b1[63:60];
        run_to(11'd510);
        upd_valid = 1'b1;
        new_board = b2;
        tick();
        upd_valid = 1'b0;
        checks++;
        if (upd_ready !== 1'b0) begin
            errors++;
            $display("FAIL second_ready: got %b expected 0", upd_ready);
        end
        for (int n = 0; n < 600 && v_cnt != 11'd480; n++) begin
            tick();
            checks++;
            if (commit_pulse !== 1'b0 || disp_board !== b1) begin
                errors++;
                $display("FAIL second_wait: got pulse=%b disp=%h expected 0 %h",
                         commit_pulse, disp_board, b1);
            end
        end
        tick();
        checks++;
        if (commit_pulse !== 1'b0 || frame_tick !== 1'b1 || disp_board !== b1) begin
            errors++;
            $display("FAIL second_tick: got pulse=%b tick=%b disp=%h expected 0 1 %h",
                     commit_pulse, frame_tick, disp_board, b1);
        end
        tick();
        checks++;
        if (commit_pulse !== 1'b1 || disp_board !== b2 || changed_mask !== nib_diff(b2, b1)) begin
            errors++;
            $display("FAIL second_commit: got pulse=%b disp=%h mask=%h expected 1 %h %h",
                     commit_pulse, disp_board, changed_mask, b2, nib_diff(b2, b1));
        end
    endtask

    task automatic test_hold();
        logic [15:0] em;
        logic [63:0] pa;
        int k;
        int n;
        for (int ph = 0; ph < 2; ph++) begin
            em = m_mask;
            if (ph == 1) begin
                pa = m_disp ^ 64'h0000_0000_0000_00F0;
                upd_valid = 1'b1;
                new_board = pa;
                tick();
                upd_valid = 1'b0;
                for (n = 0; n < 600 && !commit_pulse; n++) tick();
                for (n = 0; n < 600 && !frame_tick; n++) tick();
                run_to(11'd500);
                checks++;
                if (hl_active !== 1'b1 || changed_mask !== 16'h0002) begin
                    errors++;
                    $display("FAIL hold_pre_reload: got hl=%b mask=%h expected 1 0002",
                             hl_active, changed_mask);
                end
                upd_valid = 1'b1;
                new_board = pa ^ 64'h0000_0000_0000_0F00;
                tick();
                upd_valid = 1'b0;
                tick();
                em = 16'h0004;
                checks++;
                if (commit_pulse !== 1'b1 || changed_mask !== em || hl_active !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_reload: got pulse=%b mask=%h hl=%b expected 1 0004 1",
                             commit_pulse, changed_mask, hl_active);
                end
            end
            checks++;
            if (hl_active !== 1'b1) begin
                errors++;
                $display("FAIL hold_start: got %b expected 1", hl_active);
            end
            k = 0;
            for (n = 0; n < 2000 && k < 3; n++) begin
                tick();
                if (frame_tick) begin
                    k++;
                    tick();
                    checks++;
                    if (hl_active !== (k < 3) || changed_mask !== ((k < 3) ? em : 16'h0) ||
                        dutv() !== mexp()) begin
                        errors++;
                        $display("FAIL hold_tick%0d: got hl=%b mask=%h expected %b %h",
                                 k, hl_active, changed_mask, (k < 3), ((k < 3) ? em : 16'h0));
                    end
                end
            end
            checks++;
            if (k != 3) begin
                errors++;
                $display("FAIL hold_timeout: got %0d ticks expected 3", k);
            end
        end
    endtask

    task automatic test_reset_wait();
        run_to(11'd0);
        run_to(11'd200);
        upd_valid = 1'b1;
        new_board = m_disp ^ 64'h0123_4567_89AB_CDEF;
        tick();
        upd_valid = 1'b0;
        checks++;
        if (upd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rw_ready: got %b expected 0", upd_ready);
        end
        run_to(11'd300);
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dutv() !== {1'b1, 83'd0}) begin
            errors++;
            $display("FAIL rw_reset: got %h expected %h", dutv(), {1'b1, 83'd0});
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++;
            if (commit_pulse !== 1'b0 || disp_board !== 64'd0 || upd_ready !== 1'b1) begin
                errors++;
                $display("FAIL rw_nocommit: got pulse=%b disp=%h ready=%b expected 0 0 1",
                         commit_pulse, disp_board, upd_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2100; i++) begin
            upd_valid = ($urandom_range(0, 7) == 0);
            new_board = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) new_board = m_disp;
            tick();
            checks++;
            if (dutv() !== mexp()) begin
                errors++;
                $display("FAIL random_cyc%0d: got %h expected %h", i, dutv(), mexp());
            end
        end
        upd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        test_reset();
        test_active_update();
        test_vblank_update();
        test_second_same_frame();
        test_hold();
        test_reset_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
